ctrl_pipe: RTL

Downstream consumer of the 32-bit control word emitted by the instruction decoder. It carries that word, together with register indices, through the ID/EX, EX/MEM and MEM/WB pipeline registers of the pipelined CPU. It also produces the load-use stall, the bubble insertion on branch flush, and the ALU operand forwarding selects. It sits between the decoder and the EX/MEM/WB datapath; it contains no datapath values, only control.

---
 rtl/ctrl_pipe.sv | 107 ++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoder control word and register indices through
// ID/EX, EX/MEM and MEM/WB. Generates the load-use stall, the flush bubble,
// the ALU operand forwarding selects and a saturating stall-cycle counter.
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      ctrl_id,
  input  logic [4:0]       rd_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             flush,
  output logic [31:0]      ctrl_ex,
  output logic [31:0]      ctrl_mem,
  output logic [31:0]      ctrl_wb,
  output logic [4:0]       rd_ex,
  output logic [4:0]       rd_mem,
  output logic [4:0]       rd_wb,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] M_LOAD = 2'd2;
  localparam int         B_WB   = 12;

  logic [4:0] rs1_ex;
  logic [4:0] rs2_ex;
  logic       hazard;
  logic       bubble;

  // MEM result has priority over the older WB value for the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [31:0] c_mem,
    input logic [4:0]  r_mem,
    input logic [31:0] c_wb,
    input logic [4:0]  r_wb
  );
    if (c_mem[B_WB] && (r_mem != 5'd0) && (r_mem == rs))
      return 2'd1;
    else if (c_wb[B_WB] && (r_wb != 5'd0) && (r_wb == rs))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  // Load-use detection; a taken branch flushes ID anyway, so it suppresses the stall.
  always_comb begin
    hazard = (ctrl_ex[9:8] == M_LOAD) && (rd_ex != 5'd0) &&
             ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    stall  = hazard && !flush;
    bubble = flush || stall;
  end

  // Operand selects for the instruction currently in EX.
  always_comb begin
    fwd_a = fwd_sel(rs1_ex, ctrl_mem, rd_mem, ctrl_wb, rd_wb);
    fwd_b = fwd_sel(rs2_ex, ctrl_mem, rd_mem, ctrl_wb, rd_wb);
  end

  // ID/EX register: takes the decoded instruction or an all-zero bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_ex <= '0;
      rd_ex   <= '0;
      rs1_ex  <= '0;
      rs2_ex  <= '0;
    end else if (bubble) begin
      ctrl_ex <= '0;
      rd_ex   <= '0;
      rs1_ex  <= '0;
      rs2_ex  <= '0;
    end else begin
      ctrl_ex <= ctrl_id;
      rd_ex   <= rd_id;
      rs1_ex  <= rs1_id;
      rs2_ex  <= rs2_id;
    end
  end

  // EX/MEM and MEM/WB advance unconditionally every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_mem <= '0;
      rd_mem   <= '0;
      ctrl_wb  <= '0;
      rd_wb    <= '0;
    end else begin
      ctrl_mem <= ctrl_ex;
      rd_mem   <= rd_ex;
      ctrl_wb  <= ctrl_mem;
      rd_wb    <= rd_mem;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
